// File: rtl/malloc_arbiter.sv
// malloc_arbiter: shares the single malloc engine among all cores.
// One level-sensitive request per core. Each transaction picks one winner,
// runs the engine's cs/operand handshake and returns the result as a
// one-cycle done pulse.
// Optional feature macro: MALLOC_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, the lowest requesting index wins (fixed priority).
// The mpu_common package below carries the shared widths and the error type.

package mpu_common;
    localparam int CORE_COUNT       = 4;
    localparam int CORE_ID_WIDTH    = 2;
    localparam int BLOCK_COUNT_BITS = 8;
    localparam int ADDR_WIDTH       = 16;

    typedef enum logic [1:0] {
        MALLOC_NO_ERROR     = 2'd0,
        OUT_OF_MEMORY       = 2'd1,
        MALLOC_INVALID_SIZE = 2'd2
    } malloc_error_t;
endpackage

// Handshake semantics:
//   Core side: req[i] is a level held until gnt[i]. gnt[i] is a one-cycle
//   pulse meaning the operands were captured. done[i] is a later one-cycle
//   pulse with resp_* valid.
//   Engine side: m_cs is a one-cycle start strobe with m_* operands stable.
//   m_rdy is a one-cycle result strobe with m_base_addr/m_err valid.
//   m_cs is only raised from ARB_IDLE with m_bsy low.
module malloc_arbiter
    import mpu_common::*;
(
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [CORE_COUNT-1:0]                        req,
    input  logic [CORE_COUNT-1:0][BLOCK_COUNT_BITS-1:0]  req_num_blocks,
    input  logic [CORE_COUNT-1:0][CORE_COUNT-1:0]        req_read_mask,
    input  logic [CORE_COUNT-1:0][CORE_COUNT-1:0]        req_write_mask,
    output logic [CORE_COUNT-1:0]                        gnt,
    output logic [CORE_COUNT-1:0]                        done,
    output logic [ADDR_WIDTH-1:0]                        resp_base_addr,
    output malloc_error_t                                resp_err,
    output logic                                         arb_bsy,
    output logic                                         m_cs,
    output logic [CORE_ID_WIDTH-1:0]                     m_core_id,
    output logic [BLOCK_COUNT_BITS-1:0]                  m_num_blocks,
    output logic [CORE_COUNT-1:0]                        m_read_mask,
    output logic [CORE_COUNT-1:0]                        m_write_mask,
    input  logic                                         m_rdy,
    input  logic                                         m_bsy,
    input  logic [ADDR_WIDTH-1:0]                        m_base_addr,
    input  malloc_error_t                                m_err
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    arb_state_t                  state, state_d;
    logic [CORE_ID_WIDTH-1:0]    winner;
    logic [CORE_ID_WIDTH-1:0]    idx_v;

    logic [CORE_COUNT-1:0]       gnt_d, done_d;
    logic [ADDR_WIDTH-1:0]       resp_base_addr_d;
    malloc_error_t               resp_err_d;
    logic                        arb_bsy_d, m_cs_d;
    logic [CORE_ID_WIDTH-1:0]    m_core_id_d;
    logic [BLOCK_COUNT_BITS-1:0] m_num_blocks_d;
    logic [CORE_COUNT-1:0]       m_read_mask_d, m_write_mask_d;

`ifdef MALLOC_ARB_RR_EN
    logic [CORE_ID_WIDTH-1:0]    last_grant, last_grant_d;

    // Winner: first asserted req searching upward from last_grant+1, wrapping.
    always_comb begin
        winner = '0;
        idx_v  = '0;
        for (int k = CORE_COUNT; k >= 1; k--) begin
            idx_v = CORE_ID_WIDTH'((int'(last_grant) + k) % CORE_COUNT);
            if (req[idx_v]) begin
                winner = idx_v;
            end
        end
    end
`else
    // Winner: lowest asserted req index.
    always_comb begin
        winner = '0;
        idx_v  = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            idx_v = CORE_ID_WIDTH'(i);
            if (req[idx_v]) begin
                winner = idx_v;
            end
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d          = state;
        gnt_d            = '0;
        done_d           = '0;
        m_cs_d           = 1'b0;
        arb_bsy_d        = arb_bsy;
        resp_base_addr_d = resp_base_addr;
        resp_err_d       = resp_err;
        m_core_id_d      = m_core_id;
        m_num_blocks_d   = m_num_blocks;
        m_read_mask_d    = m_read_mask;
        m_write_mask_d   = m_write_mask;
`ifdef MALLOC_ARB_RR_EN
        last_grant_d     = last_grant;
`endif
        case (state)
            ARB_IDLE: begin
                arb_bsy_d = 1'b0;
                if ((req != '0) && !m_bsy) begin
                    state_d          = ARB_WAIT;
                    gnt_d[winner]    = 1'b1;
                    m_cs_d           = 1'b1;
                    arb_bsy_d        = 1'b1;
                    m_core_id_d      = winner;
                    m_num_blocks_d   = req_num_blocks[winner];
                    m_read_mask_d    = req_read_mask[winner];
                    m_write_mask_d   = req_write_mask[winner];
                end
            end
            ARB_WAIT: begin
                if (m_rdy) begin
                    state_d           = ARB_RESP;
                    resp_base_addr_d  = m_base_addr;
                    resp_err_d        = m_err;
                    done_d[m_core_id] = 1'b1;
`ifdef MALLOC_ARB_RR_EN
                    last_grant_d      = m_core_id;
`endif
                end
            end
            ARB_RESP: begin
                // The engine has already dropped m_bsy by this cycle.
                state_d          = ARB_IDLE;
                arb_bsy_d        = 1'b0;
                resp_base_addr_d = '0;
                resp_err_d       = MALLOC_NO_ERROR;
            end
            default: begin
                state_d          = ARB_IDLE;
                arb_bsy_d        = 1'b0;
                resp_base_addr_d = '0;
                resp_err_d       = MALLOC_NO_ERROR;
                m_core_id_d      = '0;
                m_num_blocks_d   = '0;
                m_read_mask_d    = '0;
                m_write_mask_d   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Output and operand registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt            <= '0;
            done           <= '0;
            m_cs           <= 1'b0;
            arb_bsy        <= 1'b0;
            resp_base_addr <= '0;
            resp_err       <= MALLOC_NO_ERROR;
            m_core_id      <= '0;
            m_num_blocks   <= '0;
            m_read_mask    <= '0;
            m_write_mask   <= '0;
`ifdef MALLOC_ARB_RR_EN
            last_grant     <= CORE_ID_WIDTH'(CORE_COUNT - 1);
`endif
        end else begin
            gnt            <= gnt_d;
            done           <= done_d;
            m_cs           <= m_cs_d;
            arb_bsy        <= arb_bsy_d;
            resp_base_addr <= resp_base_addr_d;
            resp_err       <= resp_err_d;
            m_core_id      <= m_core_id_d;
            m_num_blocks   <= m_num_blocks_d;
            m_read_mask    <= m_read_mask_d;
            m_write_mask   <= m_write_mask_d;
`ifdef MALLOC_ARB_RR_EN
            last_grant     <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_malloc_arbiter.sv
// tb_malloc_arbiter: scoreboard bench for malloc_arbiter with a behavioural
// malloc engine stub. It works in both the round-robin build and the
// fixed-priority build (MALLOC_ARB_RR_EN).
module tb_malloc_arbiter;
    import mpu_common::*;

    localparam int N  = CORE_COUNT;
    localparam int GW = N + CORE_ID_WIDTH + BLOCK_COUNT_BITS + 2 * N;
    localparam int DW = N + ADDR_WIDTH + 2 + BLOCK_COUNT_BITS;
    localparam int EW = 8 + ADDR_WIDTH + 2;

    logic                                 clk;
    logic                                 rst_n;
    logic [N-1:0]                         req;
    logic [N-1:0][BLOCK_COUNT_BITS-1:0]   req_num_blocks;
    logic [N-1:0][N-1:0]                  req_read_mask;
    logic [N-1:0][N-1:0]                  req_write_mask;
    logic [N-1:0]                         gnt;
    logic [N-1:0]                         done;
    logic [ADDR_WIDTH-1:0]                resp_base_addr;
    malloc_error_t                        resp_err;
    logic                                 arb_bsy;
    logic                                 m_cs;
    logic [CORE_ID_WIDTH-1:0]             m_core_id;
    logic [BLOCK_COUNT_BITS-1:0]          m_num_blocks;
    logic [N-1:0]                         m_read_mask;
    logic [N-1:0]                         m_write_mask;
    logic                                 m_rdy;
    logic                                 m_bsy;
    logic [ADDR_WIDTH-1:0]                m_base_addr;
    malloc_error_t                        m_err;

    logic [GW-1:0] exp_gnt_q[$];
    logic [DW-1:0] exp_done_q[$];
    logic [EW-1:0] eng_q[$];

    int tests = 0;
    int fails = 0;
    int model_last = N - 1;

    malloc_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_num_blocks(req_num_blocks), .req_read_mask(req_read_mask),
        .req_write_mask(req_write_mask), .gnt(gnt), .done(done),
        .resp_base_addr(resp_base_addr), .resp_err(resp_err), .arb_bsy(arb_bsy),
        .m_cs(m_cs), .m_core_id(m_core_id), .m_num_blocks(m_num_blocks),
        .m_read_mask(m_read_mask), .m_write_mask(m_write_mask), .m_rdy(m_rdy),
        .m_bsy(m_bsy), .m_base_addr(m_base_addr), .m_err(m_err)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference arbitration: who should win, given a request pattern.
    function automatic int model_winner(input logic [N-1:0] pat);
`ifdef MALLOC_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (pat[(model_last + k) % N]) return (model_last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (pat[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic check_reset_outputs();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_m_cs", 32'(m_cs), 0);
        check("rst_arb_bsy", 32'(arb_bsy), 0);
        check("rst_resp_base_addr", 32'(resp_base_addr), 0);
        check("rst_resp_err", 32'(resp_err), 32'(MALLOC_NO_ERROR));
        check("rst_m_core_id", 32'(m_core_id), 0);
        check("rst_m_num_blocks", 32'(m_num_blocks), 0);
        check("rst_m_read_mask", 32'(m_read_mask), 0);
        check("rst_m_write_mask", 32'(m_write_mask), 0);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("gnt_timeout");
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("done_timeout");
    endtask

    // Set up one transaction: randomize operands, predict winner and result,
    // feed the engine stub, then drive req and follow it to done.
    task automatic txn(input logic [N-1:0] pat, input bit hold, input int nb_f,
                       input int base_f, input int err_f, input int lat_f, input bit to_done);
        int w, lat;
        bit ok;
        logic [CORE_ID_WIDTH-1:0] wi;
        logic [N-1:0] oh;
        logic [ADDR_WIDTH-1:0] base;
        logic [1:0] err2;
        w  = model_winner(pat);
        wi = CORE_ID_WIDTH'(w);
        oh = '0;
        oh[wi] = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_num_blocks[i] = BLOCK_COUNT_BITS'($urandom_range(1, 255));
            req_read_mask[i]  = N'($urandom);
            req_write_mask[i] = N'($urandom);
        end
        if (nb_f >= 0) req_num_blocks[wi] = BLOCK_COUNT_BITS'(nb_f);
        lat  = (lat_f >= 0) ? lat_f : $urandom_range(1, 5);
        err2 = (err_f >= 0) ? 2'(err_f) : 2'($urandom_range(0, 2));
        base = (base_f >= 0) ? ADDR_WIDTH'(base_f) : ADDR_WIDTH'($urandom);
        if (err2 == 2'(OUT_OF_MEMORY)) base = '0;
        exp_gnt_q.push_back({oh, wi, req_num_blocks[wi], req_read_mask[wi], req_write_mask[wi]});
        eng_q.push_back({8'(lat), base, err2});
        if (to_done) exp_done_q.push_back({oh, base, err2, req_num_blocks[wi]});
        model_last = w;
        req = pat;
        wait_gnt(ok);
        if (!ok) return;
        @(posedge clk); #1;
        // Late operand change on the granted core must not reach the engine.
        req_num_blocks[wi] = req_num_blocks[wi] ^ BLOCK_COUNT_BITS'(4);
        if (!hold) req = '0;
        if (to_done) wait_done(ok);
    endtask

    // Behavioural malloc engine: busy from the cycle after cs, result after lat.
    initial begin
        logic [EW-1:0] e;
        logic [7:0] lat8;
        logic [1:0] err2;
        logic [ADDR_WIDTH-1:0] r_base;
        malloc_error_t r_err;
        int cnt;
        bit busy, rdy_now;
        busy = 1'b0; rdy_now = 1'b0; cnt = 0;
        r_base = '0; r_err = MALLOC_NO_ERROR;
        m_rdy = 1'b0; m_bsy = 1'b0; m_base_addr = '0; m_err = MALLOC_NO_ERROR;
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin
                busy = 1'b0; rdy_now = 1'b0;
                m_rdy = 1'b0; m_bsy = 1'b0; m_base_addr = '0; m_err = MALLOC_NO_ERROR;
            end else if (busy) begin
                if (rdy_now) begin
                    m_rdy = 1'b0; m_bsy = 1'b0; m_base_addr = '0; m_err = MALLOC_NO_ERROR;
                    busy = 1'b0; rdy_now = 1'b0;
                end else if (cnt == 0) begin
                    m_rdy = 1'b1; m_bsy = 1'b1; m_base_addr = r_base; m_err = r_err;
                    rdy_now = 1'b1;
                end else begin
                    m_bsy = 1'b1;
                    cnt--;
                end
            end else begin
                m_rdy = 1'b0;
                if (m_cs) begin
                    if (eng_q.size() == 0) begin
                        flag("unexpected_m_cs");
                    end else begin
                        e = eng_q.pop_front();
                        {lat8, r_base, err2} = e;
                        r_err = malloc_error_t'(err2);
                        cnt = int'(lat8);
                        busy = 1'b1;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    // Stray result strobe while the arbiter is idle.
                    m_rdy = 1'b1;
                    m_base_addr = ADDR_WIDTH'($urandom);
                    m_err = malloc_error_t'(2'($urandom_range(0, 2)));
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents gnt or done.
    initial begin
        logic [GW-1:0] g;
        logic [DW-1:0] d;
        logic [N-1:0] e_oh, e_rm, e_wm;
        logic [CORE_ID_WIDTH-1:0] e_id;
        logic [BLOCK_COUNT_BITS-1:0] e_nb;
        logic [ADDR_WIDTH-1:0] e_base;
        logic [1:0] e_err;
        bit prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
                continue;
            end
            if (m_cs) check("m_cs_while_m_bsy", 32'(m_bsy), 0);
            if (m_cs && (gnt == '0)) flag("m_cs_without_gnt");
            if (gnt != '0) begin
                if (exp_gnt_q.size() == 0) begin
                    flag("unexpected_gnt");
                end else begin
                    g = exp_gnt_q.pop_front();
                    {e_oh, e_id, e_nb, e_rm, e_wm} = g;
                    check("gnt", 32'(gnt), 32'(e_oh));
                    check("gnt_m_cs", 32'(m_cs), 1);
                    check("gnt_arb_bsy", 32'(arb_bsy), 1);
                    check("m_core_id", 32'(m_core_id), 32'(e_id));
                    check("m_num_blocks", 32'(m_num_blocks), 32'(e_nb));
                    check("m_read_mask", 32'(m_read_mask), 32'(e_rm));
                    check("m_write_mask", 32'(m_write_mask), 32'(e_wm));
                end
            end
            if (prev_done) begin
                check("post_done_done", 32'(done), 0);
                check("post_done_arb_bsy", 32'(arb_bsy), 0);
                check("post_done_resp_base_addr", 32'(resp_base_addr), 0);
                check("post_done_resp_err", 32'(resp_err), 32'(MALLOC_NO_ERROR));
            end
            prev_done = (done != '0);
            if (done != '0) begin
                if (exp_done_q.size() == 0) begin
                    flag("spurious_done");
                end else begin
                    d = exp_done_q.pop_front();
                    {e_oh, e_base, e_err, e_nb} = d;
                    check("done", 32'(done), 32'(e_oh));
                    check("resp_base_addr", 32'(resp_base_addr), 32'(e_base));
                    check("resp_err", 32'(resp_err), 32'(e_err));
                    check("done_m_num_blocks_held", 32'(m_num_blocks), 32'(e_nb));
                    check("done_arb_bsy", 32'(arb_bsy), 1);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        bit held;
        bit ok;
        logic [N-1:0] pat;
        rst_n = 1'b0;
        req = '0;
        req_num_blocks = '0;
        req_read_mask = '0;
        req_write_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request from core 2, three blocks, base 0x40.
        txn(N'(4), 1'b0, 3, 'h40, int'(MALLOC_NO_ERROR), -1, 1'b1);

        // All cores requesting, held across transactions.
        for (int k = 0; k < 5; k++) txn(N'(15), (k < 4), -1, -1, -1, -1, 1'b1);

        // Cores 1 and 3 requesting, held; then only core 3.
        for (int k = 0; k < 4; k++) txn(N'(10), (k < 3), -1, -1, -1, -1, 1'b1);
        txn(N'(8), 1'b0, -1, -1, -1, -1, 1'b1);

        // Out-of-memory result, then a normal one.
        txn(N'($urandom_range(1, 15)), 1'b0, -1, 0, int'(OUT_OF_MEMORY), -1, 1'b1);
        txn(N'($urandom_range(1, 15)), 1'b0, -1, -1, int'(MALLOC_NO_ERROR), -1, 1'b1);

        // Randomized traffic, sometimes holding the same pattern.
        held = 1'b0;
        pat = N'(1);
        for (int t = 0; t < 30; t++) begin
            if (!held) pat = N'($urandom_range(1, (1 << N) - 1));
            held = ($urandom_range(0, 2) == 0) && (t != 29);
            txn(pat, held, -1, -1, -1, -1, 1'b1);
        end

        // Reset while the arbiter waits on the engine: result is dropped.
        repeat (3) @(posedge clk);
        #1;
        txn(N'(6), 1'b0, -1, -1, -1, 12, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        rst_n = 1'b1;
        model_last = N - 1;
        repeat (20) @(posedge clk);
        #1;
        txn(N'(15), 1'b0, -1, -1, -1, -1, 1'b1);
        txn(N'(15), 1'b0, -1, -1, -1, -1, 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("exp_gnt_q_drained", 32'(exp_gnt_q.size()), 0);
        check("exp_done_q_drained", 32'(exp_done_q.size()), 0);
        check("eng_q_drained", 32'(eng_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
